hdma_engine: RTL and testbench

CGB VRAM DMA engine: the consumer end of the HDMA1–HDMA5 / DMA_start / GDMA_finished handshake produced by the special-register block. It runs two kinds of transfer:
- general-purpose DMA, one uninterrupted burst;
- H-Blank DMA, one 16-byte block per H-Blank entry.

Data moves from a source address to VRAM (0x8000–0x9FFF) over a dedicated memory port. While that port is in use, the CPU is stalled.

---
 rtl/hdma_engine.sv | 106 ++++++++++
 tb/tb_hdma_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdma_engine.sv
// CGB VRAM DMA engine: copies 16-byte blocks from a source address into VRAM,
// either as one general-purpose burst or one block per H-Blank entry.
module hdma_engine (
    input  logic        clk4_2,
    input  logic        reset_n,
    input  logic        DMA_start,
    input  logic [7:0]  HDMA1,
    input  logic [7:0]  HDMA2,
    input  logic [7:0]  HDMA3,
    input  logic [7:0]  HDMA4,
    input  logic [7:0]  HDMA5,
    input  logic [1:0]  STAT_mode,
    input  logic [7:0]  dma_rdata,
    output logic [15:0] dma_addr,
    output logic        dma_read,
    output logic        dma_write,
    output logic [7:0]  dma_wdata,
    output logic        dma_active,
    output logic        hdma_busy,
    output logic [6:0]  hdma_remaining,
    output logic        GDMA_finished
);

    typedef enum logic [1:0] {IDLE, WAIT_HB, READ, WRITE} state_t;

    state_t      state;
    logic [15:0] src;
    logic [12:0] dst;
    logic [6:0]  blk;
    logic [3:0]  cnt;
    logic        mode;
    logic [1:0]  prev_mode;
    logic        finished;
    logic        hb_entry;
    logic        load;
    logic        unused_hdma;

    // Address bits below block alignment and above the VRAM window are ignored.
    assign unused_hdma = ^{HDMA2[3:0], HDMA3[7:5], HDMA4[3:0]};

    assign hb_entry = (prev_mode != 2'b00) && (STAT_mode == 2'b00);
    // A new H-Blank request while armed re-latches instead of cancelling.
    assign load     = DMA_start && ((state == IDLE) || ((state == WAIT_HB) && HDMA5[7]));

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            src       <= 16'h0000;
            dst       <= 13'h0000;
            blk       <= 7'd0;
            cnt       <= 4'd0;
            mode      <= 1'b0;
            prev_mode <= 2'b00;
            finished  <= 1'b0;
        end else begin
            prev_mode <= STAT_mode;
            finished  <= 1'b0;
            if (load) begin
                src   <= {HDMA1, HDMA2[7:4], 4'h0};
                dst   <= {HDMA3[4:0], HDMA4[7:4], 4'h0};
                blk   <= HDMA5[6:0];
                mode  <= HDMA5[7];
                cnt   <= 4'd0;
                state <= HDMA5[7] ? WAIT_HB : READ;
            end else begin
                case (state)
                    WAIT_HB: begin
                        if (DMA_start) begin
                            state    <= IDLE;
                            finished <= 1'b1;
                        end else if (hb_entry) begin
                            state <= READ;
                        end
                    end
                    READ: state <= WRITE;
                    WRITE: begin
                        src <= src + 16'd1;
                        dst <= dst + 13'd1;
                        cnt <= cnt + 4'd1;
                        if (cnt != 4'hF) begin
                            state <= READ;
                        end else if (blk == 7'd0) begin
                            state    <= IDLE;
                            finished <= 1'b1;
                        end else begin
                            blk   <= blk - 7'd1;
                            state <= mode ? WAIT_HB : READ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign dma_read       = (state == READ);
    assign dma_write      = (state == WRITE);
    assign dma_active     = dma_read || dma_write;
    assign hdma_busy      = (state != IDLE);
    assign hdma_remaining = blk;
    assign GDMA_finished  = finished;
    assign dma_addr       = dma_read  ? src :
                            dma_write ? {3'b100, dst} : 16'h0000;
    assign dma_wdata      = dma_write ? dma_rdata : 8'h00;

endmodule

// File: tb/tb_hdma_engine.sv
// Bench for hdma_engine: a transfer-plan model predicts every cycle's outputs,
// directed scenarios pin the model with literal values, then random traffic.
module tb_hdma_engine;

    logic        clk4_2 = 1'b0;
    logic        reset_n = 1'b0;
    logic        DMA_start = 1'b0;
    logic [7:0]  HDMA1 = 8'h00, HDMA2 = 8'h00, HDMA3 = 8'h00, HDMA4 = 8'h00, HDMA5 = 8'h00;
    logic [1:0]  STAT_mode = 2'b00;
    logic [7:0]  dma_rdata = 8'h00;
    logic [15:0] dma_addr;
    logic        dma_read, dma_write, dma_active, hdma_busy, GDMA_finished;
    logic [7:0]  dma_wdata;
    logic [6:0]  hdma_remaining;

    hdma_engine dut (
        .clk4_2(clk4_2), .reset_n(reset_n), .DMA_start(DMA_start),
        .HDMA1(HDMA1), .HDMA2(HDMA2), .HDMA3(HDMA3), .HDMA4(HDMA4), .HDMA5(HDMA5),
        .STAT_mode(STAT_mode), .dma_rdata(dma_rdata), .dma_addr(dma_addr),
        .dma_read(dma_read), .dma_write(dma_write), .dma_wdata(dma_wdata),
        .dma_active(dma_active), .hdma_busy(hdma_busy),
        .hdma_remaining(hdma_remaining), .GDMA_finished(GDMA_finished)
    );

    always #5 clk4_2 = ~clk4_2;

    logic [7:0] mem [0:65535];
    always @(posedge clk4_2) if (dma_read) dma_rdata <= mem[dma_addr];

    // One record per expected active cycle of the memory port.
    typedef struct packed {
        logic        rd, wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [6:0]  rem, rem_after;
        logic        blk_end, last;
    } rec_t;
    rec_t plan[$];

    logic [15:0] m_src;
    logic [12:0] m_dst;
    logic [6:0]  m_blk, m_rem;
    logic        m_busy = 1'b0, m_fin = 1'b0;
    logic [1:0]  prev_stat = 2'b00;

    int checks = 0, errors = 0;
    int cyc = 0, e0 = 0;
    int act_cnt = 0, fin_cnt = 0, fin_idx = 0;
    logic [15:0] rd_log[$], wr_log[$], rem_log[$];

    function automatic void push_block(input logic [15:0] s, input logic [12:0] d,
                                       input logic [6:0] rem, input bit last);
        rec_t r;
        for (int i = 0; i < 16; i++) begin
            r = '0; r.rd = 1'b1; r.addr = s + 16'(i); r.rem = rem;
            plan.push_back(r);
            r = '0; r.wr = 1'b1; r.addr = 16'h8000 | {3'b000, d + 13'(i)};
            r.wdata = mem[s + 16'(i)]; r.rem = rem;
            if (i == 15) begin
                r.blk_end = 1'b1; r.last = last;
                r.rem_after = last ? rem : rem - 7'd1;
            end
            plan.push_back(r);
        end
    endfunction

    // Model: advances the transfer plan on every rising edge.
    initial begin : model
        rec_t r;
        bit   entry;
        forever begin
            @(posedge clk4_2);
            cyc++;
            if (!reset_n) begin
                plan.delete(); m_busy = 0; m_fin = 0; m_rem = 0; prev_stat = 0;
            end else begin
                m_fin = 0;
                entry = (prev_stat != 2'b00) && (STAT_mode == 2'b00);
                if (plan.size() != 0) begin
                    r = plan.pop_front();
                    if (r.blk_end) m_rem = r.rem_after;
                    if (r.last) begin m_busy = 0; m_fin = 1; end
                end else if (DMA_start && (!m_busy || HDMA5[7])) begin
                    m_src = {HDMA1, HDMA2[7:4], 4'h0};
                    m_dst = {HDMA3[4:0], HDMA4[7:4], 4'h0};
                    m_blk = HDMA5[6:0]; m_rem = m_blk; m_busy = 1;
                    if (!HDMA5[7])
                        for (int k = 0; k <= int'(m_blk); k++)
                            push_block(m_src + 16'(16 * k), m_dst + 13'(16 * k),
                                       m_blk - 7'(k), k == int'(m_blk));
                end else if (DMA_start && m_busy) begin
                    m_busy = 0; m_fin = 1;
                end else if (m_busy && entry) begin
                    push_block(m_src, m_dst, m_blk, m_blk == 7'd0);
                    m_src += 16'd16; m_dst += 13'd16;
                    if (m_blk != 7'd0) m_blk--;
                end
                prev_stat = STAT_mode;
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin : cmp
        rec_t r;
        logic w_act, w_rd, w_wr, w_busy, w_fin, ok;
        logic [15:0] w_addr;
        logic [7:0]  w_wdata;
        logic [6:0]  w_rem;
        forever begin
            @(negedge clk4_2);
            r = '0;
            if (!reset_n) begin
                w_act = 0; w_busy = 0; w_rem = 0; w_fin = 0;
            end else if (plan.size() != 0) begin
                r = plan[0]; w_act = 1; w_busy = 1; w_rem = r.rem; w_fin = 0;
            end else begin
                w_act = 0; w_busy = m_busy; w_rem = m_rem; w_fin = m_fin;
            end
            w_rd = r.rd; w_wr = r.wr; w_addr = r.addr; w_wdata = r.wdata;
            ok = (dma_active === w_act) && (dma_read === w_rd) && (dma_write === w_wr)
                 && (hdma_busy === w_busy) && (hdma_remaining === w_rem)
                 && (GDMA_finished === w_fin);
            if (!reset_n || w_act) ok = ok && (dma_addr === w_addr);
            if (!reset_n || w_wr)  ok = ok && (dma_wdata === w_wdata);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle_outputs @%0d: got act=%0d rd=%0d wr=%0d addr=%h wdata=%h busy=%0d rem=%0d fin=%0d; want act=%0d rd=%0d wr=%0d addr=%h wdata=%h busy=%0d rem=%0d fin=%0d",
                         cyc, dma_active, dma_read, dma_write, dma_addr, dma_wdata, hdma_busy,
                         hdma_remaining, GDMA_finished, w_act, w_rd, w_wr, w_addr, w_wdata,
                         w_busy, w_rem, w_fin);
            end
        end
    end

    // Activity log for the literal expectations.
    initial begin : mon
        logic prev_act = 1'b0;
        forever begin
            @(negedge clk4_2);
            if (reset_n) begin
                if (dma_active) act_cnt++;
                if (dma_read) rd_log.push_back(dma_addr);
                if (dma_write) wr_log.push_back(dma_addr);
                if (GDMA_finished) begin fin_cnt++; fin_idx = cyc - e0 + 1; end
                if (dma_active && !prev_act) rem_log.push_back({9'd0, hdma_remaining});
            end
            prev_act = dma_active;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic int qget(input logic [15:0] q[$], input int i);
        if (i < q.size()) return int'(q[i]);
        return -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk4_2); #2; end
    endtask

    task automatic clear_logs();
        act_cnt = 0; fin_cnt = 0; fin_idx = 0;
        rd_log.delete(); wr_log.delete(); rem_log.delete();
    endtask

    task automatic start_dma(input logic [7:0] a, b, c, d, e);
        HDMA1 = a; HDMA2 = b; HDMA3 = c; HDMA4 = d; HDMA5 = e;
        DMA_start = 1'b1;
        tick(1);
        e0 = cyc;
        DMA_start = 1'b0;
    endtask

    task automatic wait_fin(input int want, input int budget);
        int n = 0;
        while (fin_cnt < want && n < budget) begin tick(1); n++; end
        if (n >= budget) chk("wait_fin_timeout", fin_cnt, want);
        tick(2);
    endtask

    task automatic hb_entry_pulse();
        STAT_mode = 2'b11; tick(3);
        STAT_mode = 2'b00;
    endtask

    initial begin : main
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        tick(3);
        chk("reset_busy", hdma_busy, 0);
        chk("reset_addr", dma_addr, 0);
        reset_n = 1'b1;
        tick(2);

        // General DMA, single block.
        clear_logs();
        start_dma(8'hC0, 8'h05, 8'h81, 8'h23, 8'h00);
        wait_fin(1, 100);
        chk("gen_active_cycles", act_cnt, 32);
        chk("gen_first_read", qget(rd_log, 0), 16'hC000);
        chk("gen_last_read", qget(rd_log, 15), 16'hC00F);
        chk("gen_first_write", qget(wr_log, 0), 16'h8120);
        chk("gen_last_write", qget(wr_log, 15), 16'h812F);
        chk("gen_fin_count", fin_cnt, 1);
        chk("gen_fin_cycle", fin_idx, 33);

        // Destination wrap.
        clear_logs();
        start_dma(8'hC0, 8'h00, 8'h1F, 8'hF0, 8'h01);
        wait_fin(1, 150);
        chk("dwrap_active_cycles", act_cnt, 64);
        chk("dwrap_write15", qget(wr_log, 15), 16'h9FFF);
        chk("dwrap_write16", qget(wr_log, 16), 16'h8000);
        chk("dwrap_write31", qget(wr_log, 31), 16'h800F);
        chk("dwrap_fin_cycle", fin_idx, 65);

        // Source wrap.
        clear_logs();
        start_dma(8'hFF, 8'hF0, 8'h80, 8'h00, 8'h01);
        wait_fin(1, 150);
        chk("swrap_read0", qget(rd_log, 0), 16'hFFF0);
        chk("swrap_read15", qget(rd_log, 15), 16'hFFFF);
        chk("swrap_read16", qget(rd_log, 16), 16'h0000);
        chk("swrap_read31", qget(rd_log, 31), 16'h000F);

        // H-Blank mode, started while already inside H-Blank.
        clear_logs();
        STAT_mode = 2'b00;
        start_dma(8'hD0, 8'h00, 8'h80, 8'h00, 8'h82);
        tick(10);
        chk("hb_no_access_before_entry", act_cnt, 0);
        chk("hb_armed_busy", hdma_busy, 1);
        chk("hb_armed_remaining", hdma_remaining, 2);
        for (int b = 0; b < 3; b++) begin
            hb_entry_pulse();
            tick(5);
            if (b == 1) STAT_mode = 2'b10;
            tick(35);
            chk("hb_block_bytes", act_cnt, 32 * (b + 1));
        end
        chk("hb_rem0", qget(rem_log, 0), 2);
        chk("hb_rem1", qget(rem_log, 1), 1);
        chk("hb_rem2", qget(rem_log, 2), 0);
        chk("hb_read16", qget(rd_log, 16), 16'hD010);
        chk("hb_write32", qget(wr_log, 32), 16'h8020);
        chk("hb_fin_count", fin_cnt, 1);
        chk("hb_done_busy", hdma_busy, 0);

        // Cancel while armed.
        clear_logs();
        start_dma(8'hD0, 8'h00, 8'h80, 8'h00, 8'h83);
        tick(5);
        start_dma(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(3);
        chk("cancel_fin_count", fin_cnt, 1);
        chk("cancel_busy", hdma_busy, 0);
        hb_entry_pulse(); tick(40);
        hb_entry_pulse(); tick(40);
        chk("cancel_no_access", act_cnt, 0);
        chk("cancel_single_pulse", fin_cnt, 1);

        // Reset during cycle 10 of a general transfer.
        clear_logs();
        start_dma(8'hC1, 8'h00, 8'h84, 8'h00, 8'h00);
        n = 0;
        while (cyc - e0 + 1 < 10 && n < 50) begin @(negedge clk4_2); n++; end
        #1 reset_n = 1'b0;
        #1;
        chk("rst_active", dma_active, 0);
        chk("rst_addr", dma_addr, 0);
        chk("rst_write", dma_write, 0);
        chk("rst_busy", hdma_busy, 0);
        tick(3);
        reset_n = 1'b1;
        clear_logs();
        tick(40);
        chk("rst_no_fin", fin_cnt, 0);
        chk("rst_no_access", act_cnt, 0);
        start_dma(8'hC1, 8'h00, 8'h84, 8'h00, 8'h00);
        wait_fin(1, 100);
        chk("post_rst_active", act_cnt, 32);
        chk("post_rst_first_write", qget(wr_log, 0), 16'h8400);
        chk("post_rst_fin_cycle", fin_idx, 33);

        // Random traffic: starts, cancels, re-latches, PPU mode changes.
        clear_logs();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) STAT_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                HDMA1 = 8'($urandom); HDMA2 = 8'($urandom);
                HDMA3 = 8'($urandom); HDMA4 = 8'($urandom);
                HDMA5 = {1'($urandom_range(0, 1)), 5'd0, 2'($urandom_range(0, 3))};
                DMA_start = 1'b1;
            end else begin
                DMA_start = 1'b0;
            end
            tick(1);
        end
        DMA_start = 1'b0;
        tick(200);
        chk("random_some_finished", int'(fin_cnt > 0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
